roi_overlay: RTL and testbench

//  Re-inserts a window-sized pixel stream into a full camera frame; the counterpart to the window-masking stage.

---
 rtl/roi_overlay_pkg.sv | 40 ++++
 rtl/roi_overlay_fifo.sv | 90 +++++++++
 rtl/roi_overlay.sv | 200 ++++++++++++++++++++
 tb/tb_roi_overlay.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roi_overlay_pkg.sv
// -----------------------------------------------------------------------------
// roi_overlay_pkg
//   Shared constants for the ROI overlay stage: default frame geometry, default
//   window placement, fill colours and the pixel-source selector type.
//   Colour constants are plain ints; users cast them to their colour width.
//   Optional feature macro used by the importing files: ROI_BORDER_EN.
// -----------------------------------------------------------------------------
package roi_overlay_pkg;

    // Default geometry (OV5640 in 640x480 mode).
    localparam int POSITION_WIDTH = 12;
    localparam int COLOR_WIDTH    = 8;
    localparam int OV5640_X       = 640;
    localparam int OV5640_Y       = 480;

    // Default window, inclusive bounds.
    localparam int PIC_X1         = 160;
    localparam int PIC_X2         = 479;
    localparam int PIC_Y1         = 120;
    localparam int PIC_Y2         = 359;

    // Fill colour used when a window pixel finds the ROI buffer empty.
    localparam int BACKROUND_R    = 8'h10;
    localparam int BACKROUND_G    = 8'h20;
    localparam int BACKROUND_B    = 8'h30;

    // Window-perimeter colour (only used with ROI_BORDER_EN).
    localparam int BORDER_R       = 8'hFF;
    localparam int BORDER_G       = 8'h80;
    localparam int BORDER_B       = 8'h00;

    // Where the merged output pixel comes from in a given cycle.
    typedef enum logic [1:0] {
        SRC_FRAME      = 2'd0,
        SRC_ROI        = 2'd1,
        SRC_BACKGROUND = 2'd2,
        SRC_BORDER     = 2'd3
    } pix_src_e;

endpackage

// File: rtl/roi_overlay_fifo.sv
// -----------------------------------------------------------------------------
// roi_fifo
//   Synchronous first-word-fall-through FIFO buffering the ROI pixel stream.
//   dout_o always shows the head entry while empty_o is low; a pop consumes it.
//   A push into a full FIFO or a pop from an empty one is ignored.
//   DEPTH must be a power of two so the pointers wrap on their own.
//   Optional feature macro (not used here): ROI_BORDER_EN.
// Ports
//   clk, rst   clock, asynchronous active-high reset (flushes the FIFO)
//   push_i     write din_i this cycle
//   pop_i      drop the head entry this cycle
//   din_i      W-bit write data
//   dout_o     W-bit head entry
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0
//   count_o    occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module roi_fifo
    import roi_overlay_pkg::*;
#(
    parameter int W     = 3 * COLOR_WIDTH,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Push and pop together leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: the pointers define which entries are live.
    // A same-cycle push lands at wr_ptr, so a pop still returns the old head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/roi_overlay.sv
// -----------------------------------------------------------------------------
// roi_overlay
//   Re-inserts a window-sized ROI pixel stream into a full camera frame.
//   Frame pixels outside the window pass through; each in-window frame pixel
//   is replaced by the next buffered ROI pixel (or the background colour if
//   the buffer is empty, which also raises the sticky underflow flag).
//   All outputs are registered: exactly one cycle from i_* to o_*.
//   Optional feature macro: ROI_BORDER_EN -- window perimeter pixels show the
//   constant border colour (they still consume an ROI pixel).
// Ports
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   i_valid, i_R/G/B   frame pixel strobe and colour
//   s_valid, s_ready   ROI stream handshake
//   s_R/G/B            ROI pixel, raster order within the window
//   o_valid            registered copy of i_valid
//   o_R/G/B            merged pixel
//   o_underflow        sticky per frame: a window pixel found the buffer empty
//   o_win_done         one-cycle pulse with the output of the last window pixel
// Handshake: an ROI pixel is transferred in every cycle where s_valid and
//   s_ready are both high; s_ready only depends on buffer occupancy and never
//   on s_valid, and the producer must hold s_R/G/B stable while stalled.
// -----------------------------------------------------------------------------
module roi_overlay
    import roi_overlay_pkg::*;
#(
    parameter int P_W        = POSITION_WIDTH,
    parameter int C_W        = COLOR_WIDTH,
    parameter int FRAME_X    = OV5640_X,
    parameter int FRAME_Y    = OV5640_Y,
    parameter int WIN_X1     = PIC_X1,
    parameter int WIN_X2     = PIC_X2,
    parameter int WIN_Y1     = PIC_Y1,
    parameter int WIN_Y2     = PIC_Y2,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           i_valid,
    input  logic [C_W-1:0] i_R,
    input  logic [C_W-1:0] i_G,
    input  logic [C_W-1:0] i_B,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [C_W-1:0] s_R,
    input  logic [C_W-1:0] s_G,
    input  logic [C_W-1:0] s_B,
    output logic           o_valid,
    output logic [C_W-1:0] o_R,
    output logic [C_W-1:0] o_G,
    output logic [C_W-1:0] o_B,
    output logic           o_underflow,
    output logic           o_win_done
);

    localparam int D_W   = 3 * C_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [P_W-1:0] X_LAST = P_W'(FRAME_X - 1);
    localparam logic [P_W-1:0] Y_LAST = P_W'(FRAME_Y - 1);
    localparam logic [P_W-1:0] WX1    = P_W'(WIN_X1);
    localparam logic [P_W-1:0] WX2    = P_W'(WIN_X2);
    localparam logic [P_W-1:0] WY1    = P_W'(WIN_Y1);
    localparam logic [P_W-1:0] WY2    = P_W'(WIN_Y2);

    localparam logic [D_W-1:0] BG_RGB =
        {C_W'(BACKROUND_R), C_W'(BACKROUND_G), C_W'(BACKROUND_B)};

    // ---------------------------------------------------------------- state
    logic [P_W-1:0]   cnt_x_q, cnt_x_d;
    logic [P_W-1:0]   cnt_y_q, cnt_y_d;
    logic             o_valid_q;
    logic [D_W-1:0]   rgb_q, rgb_d;
    logic             underflow_q, underflow_d;
    logic             win_done_q, win_done_d;
    logic             s_ready_q, s_ready_d;

    // ---------------------------------------------------------------- fifo
    logic             fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [D_W-1:0]   fifo_dout;
    logic [CNT_W-1:0] fifo_count, occ_next;

    logic             in_win, at_origin, at_win_last;
    pix_src_e         src;

    roi_fifo #(
        .W     (D_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({s_R, s_G, s_B}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------------------------------------------------------- decode
    assign in_win = i_valid
                 && (cnt_x_q >= WX1) && (cnt_x_q <= WX2)
                 && (cnt_y_q >= WY1) && (cnt_y_q <= WY2);

    assign at_origin   = (cnt_x_q == '0) && (cnt_y_q == '0);
    assign at_win_last = (cnt_x_q == WX2) && (cnt_y_q == WY2);

    // s_ready_q already implies room; the full check only guards the FIFO.
    assign fifo_push = s_valid && s_ready_q && !fifo_full;
    assign fifo_pop  = in_win && !fifo_empty;

    // Occupancy after this edge; s_ready for the next cycle is derived from it
    // so a producer holding s_valid high never overfills the buffer.
    assign occ_next  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign s_ready_d = (occ_next != CNT_W'(FIFO_DEPTH));

    // ---------------------------------------------------------------- counters
    always_comb begin
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (i_valid) begin
            if (cnt_x_q == X_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = (cnt_y_q == Y_LAST) ? '0 : cnt_y_q + 1'b1;
            end else begin
                cnt_x_d = cnt_x_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- output mux
    always_comb begin
        src = SRC_FRAME;
        if (in_win) begin
            src = fifo_empty ? SRC_BACKGROUND : SRC_ROI;
`ifdef ROI_BORDER_EN
            // Perimeter colour overrides the ROI pixel, but the pop above
            // still happens so the stream stays aligned.
            if ((cnt_x_q == WX1) || (cnt_x_q == WX2) ||
                (cnt_y_q == WY1) || (cnt_y_q == WY2)) begin
                src = SRC_BORDER;
            end
`endif
        end
    end

    always_comb begin
        rgb_d = {i_R, i_G, i_B};
        case (src)
            SRC_ROI:        rgb_d = fifo_dout;
            SRC_BACKGROUND: rgb_d = BG_RGB;
`ifdef ROI_BORDER_EN
            SRC_BORDER:     rgb_d = {C_W'(BORDER_R), C_W'(BORDER_G), C_W'(BORDER_B)};
`endif
            default:        rgb_d = {i_R, i_G, i_B};
        endcase
    end

    // ---------------------------------------------------------------- flags
    always_comb begin
        underflow_d = underflow_q;
        // Frame start clears; an underflow in the same cycle wins.
        if (i_valid && at_origin) begin
            underflow_d = 1'b0;
        end
        if (in_win && fifo_empty) begin
            underflow_d = 1'b1;
        end
        win_done_d = in_win && at_win_last;
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_x_q     <= '0;
            cnt_y_q     <= '0;
            o_valid_q   <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
            win_done_q  <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            cnt_x_q     <= cnt_x_d;
            cnt_y_q     <= cnt_y_d;
            o_valid_q   <= i_valid;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
            win_done_q  <= win_done_d;
            s_ready_q   <= s_ready_d;
        end
    end

    assign s_ready         = s_ready_q;
    assign o_valid         = o_valid_q;
    assign {o_R, o_G, o_B} = rgb_q;
    assign o_underflow     = underflow_q;
    assign o_win_done      = win_done_q;

endmodule

// File: tb/tb_roi_overlay.sv
module tb_roi_overlay;
    import roi_overlay_pkg::*;

    // Small frame so every scenario fits in a few hundred cycles.
    localparam int FX = 16, FY = 8;
    localparam int WX1 = 4, WX2 = 9, WY1 = 2, WY2 = 5;
    localparam int DEPTH = 32;
    localparam int WIN_N = (WX2 - WX1 + 1) * (WY2 - WY1 + 1);

    localparam logic [23:0] BG = {8'(BACKROUND_R), 8'(BACKROUND_G), 8'(BACKROUND_B)};
    localparam logic [23:0] BD = {8'(BORDER_R), 8'(BORDER_G), 8'(BORDER_B)};

    // ---------------------------------------------------------------- clock / reset
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic       i_valid = 1'b0, s_valid = 1'b0, s_ready;
    logic [7:0] i_R = '0, i_G = '0, i_B = '0;
    logic [7:0] s_R = '0, s_G = '0, s_B = '0;
    logic       o_valid, o_underflow, o_win_done;
    logic [7:0] o_R, o_G, o_B;

    roi_overlay #(
        .P_W(8), .C_W(8), .FRAME_X(FX), .FRAME_Y(FY),
        .WIN_X1(WX1), .WIN_X2(WX2), .WIN_Y1(WY1), .WIN_Y2(WY2),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .i_valid(i_valid), .i_R(i_R), .i_G(i_G), .i_B(i_B),
        .s_valid(s_valid), .s_ready(s_ready), .s_R(s_R), .s_G(s_G), .s_B(s_B),
        .o_valid(o_valid), .o_R(o_R), .o_G(o_G), .o_B(o_B),
        .o_underflow(o_underflow), .o_win_done(o_win_done)
    );

    int tests = 0;
    int fails = 0;

    // ---------------------------------------------------------------- bench model
    int          tb_x = 0, tb_y = 0;
    logic        uf_m = 1'b0;
    logic [23:0] exp_q[$];

    function automatic logic in_window(input int x, input int y);
        return (x >= WX1) && (x <= WX2) && (y >= WY1) && (y <= WY2);
    endfunction

    function automatic logic perim(input int x, input int y);
        return (x == WX1) || (x == WX2) || (y == WY1) || (y == WY2);
    endfunction

    function automatic logic [23:0] mk(input logic [7:0] v);
        return {v, ~v, v ^ 8'h55};
    endfunction

    function automatic logic [26:0] observed();
        return {o_valid, o_R, o_G, o_B, o_underflow, o_win_done};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        tb_x = 0;
        tb_y = 0;
        uf_m = 1'b0;
        exp_q.delete();
    endtask

    // Drives one cycle of frame and ROI inputs and predicts the outputs that
    // appear after the edge: {o_valid, rgb, underflow, win_done}.
    task automatic drive_cycle(input logic v, input logic [23:0] rgb,
                               input logic sv, input logic [23:0] srgb,
                               output logic [26:0] exp, output logic acc);
        logic        inw, done;
        logic [23:0] orgb;
        i_valid = v;
        {i_R, i_G, i_B} = rgb;
        s_valid = sv;
        {s_R, s_G, s_B} = srgb;
        acc  = sv && s_ready;
        inw  = v && in_window(tb_x, tb_y);
        orgb = rgb;
        done = 1'b0;
        if (v && tb_x == 0 && tb_y == 0) uf_m = 1'b0;
        if (inw) begin
            if (exp_q.size() == 0) begin
                orgb = BG;
                uf_m = 1'b1;
            end else begin
                orgb = exp_q.pop_front();
            end
`ifdef ROI_BORDER_EN
            if (perim(tb_x, tb_y)) orgb = BD;
`endif
            done = (tb_x == WX2) && (tb_y == WY2);
        end
        if (acc) exp_q.push_back(srgb);
        if (v) begin
            if (tb_x == FX - 1) begin
                tb_x = 0;
                tb_y = (tb_y == FY - 1) ? 0 : tb_y + 1;
            end else begin
                tb_x = tb_x + 1;
            end
        end
        exp = {v, orgb, uf_m, done};
        tick();
    endtask

    // ---------------------------------------------------------------- T1
    task automatic test_reset();
        logic [26:0] e;
        logic        a;
        sys_rst = 1'b1;
        repeat (2) tick();
        tests++;
        if ({observed(), s_ready} !== 28'd0) begin
            fails++;
            $display("FAIL reset_hold: got %h expected 0", {observed(), s_ready});
        end
        sys_rst = 1'b0;
        model_reset();
        tick();
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b expected 1", s_ready);
        end
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 24'hAABBCC, 1'b1, mk(8'(k)), e, a);
        tests++;
        if (observed() !== e) begin
            fails++;
            $display("FAIL pre_reset_stream: got %h expected %h", observed(), e);
        end
        // Asynchronous reset away from any edge: outputs must drop at once.
        sys_rst = 1'b1;
        #1;
        tests++;
        if ({observed(), s_ready} !== 28'd0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0", {observed(), s_ready});
        end
        i_valid = 1'b0;
        s_valid = 1'b0;
        tick();
        sys_rst = 1'b0;
        model_reset();
        tick();
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_midreset: got %b expected 1", s_ready);
        end
    endtask

    // ---------------------------------------------------------------- T2
    task automatic test_passthrough();
        logic [26:0] e;
        logic        a, v;
        int          n = 0, k = 0, px, py;
        while (n < FX * FY) begin
            v  = (k % 7) != 6;   // periodic idle cycles must not move counters
            px = tb_x;
            py = tb_y;
            drive_cycle(v, v ? {8'(tb_x), 8'(tb_y), 8'hC3} : 24'h5A5A5A, 1'b0, 24'h0, e, a);
            tests++;
            if (observed() !== e) begin
                fails++;
                $display("FAIL passthrough(%0d,%0d,v=%b): got %h expected %h", px, py, v, observed(), e);
            end
            if (v && px == WX1 && py == WY1) begin
                tests++;
                if ({o_R, o_G, o_B, o_underflow} !== {BG, 1'b1}) begin
                    fails++;
                    $display("FAIL first_underflow: got %h expected %h", {o_R, o_G, o_B, o_underflow}, {BG, 1'b1});
                end
            end
            if (v) n++;
            k++;
        end
    endtask

    // ---------------------------------------------------------------- T3 / T7
    task automatic test_full_overlay();
        logic [26:0] e;
        logic [23:0] want;
        logic        a;
        int          acc_n = 0, done_n = 0, idx = 0, px, py;
        for (int i = 0; i < WIN_N; i++) begin
            drive_cycle(1'b0, 24'h0, 1'b1, mk(8'(i)), e, a);
            if (a) acc_n++;
        end
        tests++;
        if (acc_n !== WIN_N) begin
            fails++;
            $display("FAIL preload_accepts: got %0d expected %0d", acc_n, WIN_N);
        end
        for (int i = 0; i < FX * FY; i++) begin
            px = tb_x;
            py = tb_y;
            drive_cycle(1'b1, {8'hEE, 8'(tb_x), 8'(tb_y)}, 1'b0, 24'h0, e, a);
            tests++;
            if (observed() !== e) begin
                fails++;
                $display("FAIL overlay(%0d,%0d): got %h expected %h", px, py, observed(), e);
            end
            if (in_window(px, py)) begin
                want = mk(8'(idx));
`ifdef ROI_BORDER_EN
                if (perim(px, py)) want = BD;
`endif
                tests++;
                if ({o_R, o_G, o_B} !== want) begin
                    fails++;
                    $display("FAIL window_index %0d: got %h expected %h", idx, {o_R, o_G, o_B}, want);
                end
                idx++;
            end
            if (o_win_done === 1'b1) done_n++;
        end
        tests++;
        if (done_n !== 1) begin
            fails++;
            $display("FAIL win_done_count: got %0d expected 1", done_n);
        end
        tests++;
        if (o_underflow !== 1'b0) begin
            fails++;
            $display("FAIL overlay_underflow: got %b expected 0", o_underflow);
        end
    endtask

    // ---------------------------------------------------------------- T4
    task automatic test_backpressure();
        logic [26:0] e;
        logic        a;
        int          acc_n = 0;
        logic [23:0] want;
        for (int k = 0; k < DEPTH + 8; k++) begin
            drive_cycle(1'b0, 24'h0, 1'b1, mk(8'(100 + acc_n)), e, a);
            if (a) acc_n++;
        end
        tests++;
        if (acc_n !== DEPTH) begin
            fails++;
            $display("FAIL full_accepts: got %0d expected %0d", acc_n, DEPTH);
        end
        tests++;
        if (s_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_when_full: got %b expected 0", s_ready);
        end
        acc_n = 0;
        while (!(tb_x == WX1 && tb_y == WY1)) begin
            drive_cycle(1'b1, 24'h123456, 1'b1, mk(8'd132), e, a);
            if (a) acc_n++;
            if (observed() !== e) begin
                tests++;
                fails++;
                $display("FAIL stall_stream: got %h expected %h", observed(), e);
            end
        end
        tests++;
        if (acc_n !== 0) begin
            fails++;
            $display("FAIL stall_accepts: got %0d expected 0", acc_n);
        end
        drive_cycle(1'b1, 24'h123456, 1'b1, mk(8'd132), e, a);
`ifdef ROI_BORDER_EN
        want = BD;
`else
        want = mk(8'd100);
`endif
        tests++;
        if ({o_R, o_G, o_B} !== want || observed() !== e) begin
            fails++;
            $display("FAIL first_pop_of_full: got %h expected %h", {o_R, o_G, o_B}, want);
        end
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_pop: got %b expected 1", s_ready);
        end
        drive_cycle(1'b0, 24'h0, 1'b1, mk(8'd132), e, a);
        tests++;
        if (a !== 1'b1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL refill_one: got accept=%b ready=%b expected accept=1 ready=0", a, s_ready);
        end
    endtask

    // ---------------------------------------------------------------- T5
    task automatic test_simultaneous();
        logic [26:0] e;
        logic        a;
        int          guard = 0;
        s_valid = 1'b0;
        while (!(in_window(tb_x, tb_y) && exp_q.size() == 1) && guard < 400) begin
            drive_cycle(1'b1, 24'h0F0F0F, 1'b0, 24'h0, e, a);
            if (observed() !== e) begin
                tests++;
                fails++;
                $display("FAIL drain_stream: got %h expected %h", observed(), e);
            end
            guard++;
        end
        tests++;
        if (guard >= 400) begin
            fails++;
            $display("FAIL drain_bound: got %0d cycles expected under 400", guard);
        end
        // Pop the single entry while pushing a new one.
        drive_cycle(1'b1, 24'h0F0F0F, 1'b1, mk(8'd200), e, a);
        tests++;
        if ({o_R, o_G, o_B} !== mk(8'd132) || a !== 1'b1) begin
            fails++;
            $display("FAIL simul_old_head: got %h acc=%b expected %h acc=1", {o_R, o_G, o_B}, a, mk(8'd132));
        end
        drive_cycle(1'b1, 24'h0F0F0F, 1'b0, 24'h0, e, a);
        tests++;
        if ({o_R, o_G, o_B} !== mk(8'd200)) begin
            fails++;
            $display("FAIL simul_new_pixel: got %h expected %h", {o_R, o_G, o_B}, mk(8'd200));
        end
        drive_cycle(1'b1, 24'h0F0F0F, 1'b0, 24'h0, e, a);
        tests++;
        if ({o_R, o_G, o_B, o_underflow} !== {BG, 1'b1}) begin
            fails++;
            $display("FAIL simul_then_empty: got %h expected %h", {o_R, o_G, o_B, o_underflow}, {BG, 1'b1});
        end
    endtask

    // ---------------------------------------------------------------- T6
    task automatic test_flag_clear();
        logic [26:0] e;
        logic        a;
        int          acc_n = 0, px, py;
        while (!(tb_x == 0 && tb_y == 0)) begin
            drive_cycle(1'b1, 24'h777777, 1'b0, 24'h0, e, a);
            if (observed() !== e) begin
                tests++;
                fails++;
                $display("FAIL frame_n_tail: got %h expected %h", observed(), e);
            end
        end
        tests++;
        if (o_underflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow_frame_n: got %b expected 1", o_underflow);
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive_cycle(1'b0, 24'h0, 1'b1, mk(8'(k + 40)), e, a);
            if (a) acc_n++;
        end
        tests++;
        if (acc_n !== DEPTH) begin
            fails++;
            $display("FAIL refill_accepts: got %0d expected %0d", acc_n, DEPTH);
        end
        for (int i = 0; i < FX * FY; i++) begin
            px = tb_x;
            py = tb_y;
            drive_cycle(1'b1, {8'(px), 8'h99, 8'(py)}, 1'b0, 24'h0, e, a);
            if (i == 0) begin
                tests++;
                if (o_underflow !== 1'b0) begin
                    fails++;
                    $display("FAIL underflow_clear: got %b expected 0", o_underflow);
                end
            end
            tests++;
            if (observed() !== e) begin
                fails++;
                $display("FAIL frame_n1(%0d,%0d): got %h expected %h", px, py, observed(), e);
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_passthrough();
        test_full_overlay();
        test_backpressure();
        test_simultaneous();
        test_flag_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
